// File: rtl/encoder_rv32i_pkg.sv
// Shared opcode constants, instruction format enum and immediate-range helper
// for the RV32I field encoder.
package encoder_rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_ISH,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } inst_fmt_t;

  // True when imm[31:msb] are all equal, i.e. imm fits a signed field whose
  // sign bit sits at position msb.
  function automatic logic sext_ok(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] t;
    t = 32'($signed(imm) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/encoder_rv32i_if.sv
// Field-input stream, encoded-word output stream and status counters of the
// RV32I encoder, bundled for connection between producer/consumer and encoder.
interface encoder_rv32i_if #(
  parameter int REG_WIDTH   = 5,
  parameter int COUNT_WIDTH = 16
);
  logic                   i_Valid;
  logic                   o_Ready;
  logic [6:0]             i_OP;
  logic [2:0]             i_Funct3;
  logic [6:0]             i_Funct7;
  logic [REG_WIDTH-1:0]   i_RS1;
  logic [REG_WIDTH-1:0]   i_RS2;
  logic [REG_WIDTH-1:0]   i_RD;
  logic [31:0]            i_IMM;
  logic                   o_Valid;
  logic                   i_Ready;
  logic [31:0]            o_Inst;
  logic                   o_Error;
  logic [COUNT_WIDTH-1:0] o_Count;
  logic [COUNT_WIDTH-1:0] o_ErrCount;

  // Encoder side
  modport slave (
    input  i_Valid, i_OP, i_Funct3, i_Funct7, i_RS1, i_RS2, i_RD, i_IMM, i_Ready,
    output o_Ready, o_Valid, o_Inst, o_Error, o_Count, o_ErrCount
  );

  // Producer / consumer side
  modport master (
    output i_Valid, i_OP, i_Funct3, i_Funct7, i_RS1, i_RS2, i_RD, i_IMM, i_Ready,
    input  o_Ready, o_Valid, o_Inst, o_Error, o_Count, o_ErrCount
  );
endinterface

// File: rtl/encoder_rv32i_sync_fifo.sv
// Single-clock FIFO; head word is driven to zero while empty so the output
// bus reads 0 whenever nothing is buffered.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Storage and pointer registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end
endmodule

// File: rtl/encoder_rv32i.sv
// RV32I field encoder: classifies the incoming fields, checks them for
// legality, packs legal ones into an instruction word and queues it.
module encoder_rv32i
  import encoder_rv32i_pkg::*;
#(
  parameter int REG_WIDTH   = 5,
  parameter int FIFO_DEPTH  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  encoder_rv32i_if.slave bus
);
  inst_fmt_t              fmt;
  logic                   fields_ok;
  logic                   imm_ok;
  logic                   legal;
  logic [31:0]            word;
  logic [4:0]             rs1, rs2, rd;
  logic [6:0]             op, f7;
  logic [2:0]             f3;
  logic [31:0]            imm;
  logic                   full, empty;
  logic                   accept;
  logic                   err_q;
  logic [COUNT_WIDTH-1:0] cnt_q, err_cnt_q;

  assign op  = bus.i_OP;
  assign f3  = bus.i_Funct3;
  assign f7  = bus.i_Funct7;
  assign imm = bus.i_IMM;
  assign rs1 = 5'(bus.i_RS1);
  assign rs2 = 5'(bus.i_RS2);
  assign rd  = 5'(bus.i_RD);

  // Ready depends only on registered occupancy, never on the offered fields
  assign accept = bus.i_Valid & ~full;

  // Format classification and opcode/funct legality
  always_comb begin
    fmt       = FMT_ILL;
    fields_ok = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC: begin fmt = FMT_U; fields_ok = 1'b1; end
      OP_JAL:           begin fmt = FMT_J; fields_ok = 1'b1; end
      OP_JALR:          begin fmt = FMT_I; fields_ok = (f3 == 3'b000); end
      OP_BRANCH:        begin fmt = FMT_B; fields_ok = (f3 != 3'b010) && (f3 != 3'b011); end
      OP_LOAD: begin
        fmt       = FMT_I;
        fields_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
      end
      OP_STORE: begin
        fmt       = FMT_S;
        fields_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          fmt       = FMT_ISH;
          fields_ok = (f7 == F7_ZERO) || (f7 == F7_ALT && f3 == 3'b101);
        end else begin
          fmt       = FMT_I;
          fields_ok = 1'b1;
        end
      end
      OP_REG: begin
        fmt       = FMT_R;
        fields_ok = (f7 == F7_ZERO) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
      end
      default: begin fmt = FMT_ILL; fields_ok = 1'b0; end
    endcase
  end

  // Immediate range/alignment check and word packing per format
  always_comb begin
    imm_ok = 1'b0;
    word   = '0;
    case (fmt)
      FMT_R: begin
        imm_ok = 1'b1;
        word   = {f7, rs2, rs1, f3, rd, op};
      end
      FMT_I: begin
        imm_ok = sext_ok(imm, 11);
        word   = {imm[11:0], rs1, f3, rd, op};
      end
      FMT_ISH: begin
        imm_ok = (imm[31:5] == '0);
        word   = {f7, imm[4:0], rs1, f3, rd, op};
      end
      FMT_S: begin
        imm_ok = sext_ok(imm, 11);
        word   = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      FMT_B: begin
        imm_ok = sext_ok(imm, 12) & ~imm[0];
        word   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      FMT_U: begin
        imm_ok = (imm[11:0] == '0);
        word   = {imm[31:12], rd, op};
      end
      FMT_J: begin
        imm_ok = sext_ok(imm, 20) & ~imm[0];
        word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: begin
        imm_ok = 1'b0;
        word   = '0;
      end
    endcase
  end

  assign legal = fields_ok & imm_ok;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_n_i (i_Reset),
    .push_i  (accept & legal),
    .din_i   (word),
    .pop_i   (bus.i_Ready),
    .dout_o  (bus.o_Inst),
    .full_o  (full),
    .empty_o (empty)
  );

  // Error pulse, wrapping word counter and saturating error counter
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      err_q     <= 1'b0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      err_q <= accept & ~legal;
      if (accept && legal) cnt_q <= cnt_q + COUNT_WIDTH'(1);
      if (accept && !legal && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + COUNT_WIDTH'(1);
    end
  end

  assign bus.o_Ready    = ~full;
  assign bus.o_Valid    = ~empty;
  assign bus.o_Error    = err_q;
  assign bus.o_Count    = cnt_q;
  assign bus.o_ErrCount = err_cnt_q;
endmodule

// File: tb/tb_encoder_rv32i.sv
module tb_encoder_rv32i;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        err_exp = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] exp_errc = '0;

  encoder_rv32i_if #(.REG_WIDTH(5), .COUNT_WIDTH(16)) bus ();

  encoder_rv32i #(.REG_WIDTH(5), .FIFO_DEPTH(2), .COUNT_WIDTH(16)) dut (
    .i_Clock (clk),
    .i_Reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output-side scoreboard: handshake flags every cycle, popped words in order
  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_valid", 32'(bus.o_Valid), 32'(exp_q.size() != 0));
      chk("o_ready", 32'(bus.o_Ready), 32'(exp_q.size() < 2));
      chk("o_error", 32'(bus.o_Error), 32'(err_exp));
      if (bus.o_Valid && bus.i_Ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL pop_unexpected observed=%h expected=none", bus.o_Inst);
        end
        if (exp_q.size() != 0) chk("o_inst", bus.o_Inst, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm);
    bus.i_OP     = op;
    bus.i_Funct3 = f3;
    bus.i_Funct7 = f7;
    bus.i_RS1    = rs1;
    bus.i_RS2    = rs2;
    bus.i_RD     = rd;
    bus.i_IMM    = imm;
    bus.i_Valid  = 1'b1;
  endtask

  // One clock: called at posedge+2, returns at the next posedge+2
  task automatic step(input bit legal, input logic [31:0] word);
    bit acc;
    @(negedge clk);
    acc = bus.i_Valid && bus.o_Ready;
    @(posedge clk);
    #2;
    err_exp = acc && !legal;
    if (acc) begin
      if (legal) begin
        exp_q.push_back(word);
        exp_cnt++;
      end else if (exp_errc != 16'hFFFF) begin
        exp_errc++;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.i_Valid = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic counts(input string tag);
    chk({tag, "_count"}, 32'(bus.o_Count), 32'(exp_cnt));
    chk({tag, "_errcount"}, 32'(bus.o_ErrCount), 32'(exp_errc));
  endtask

  initial begin
    bus.i_Valid  = 1'b0;
    bus.i_Ready  = 1'b1;
    bus.i_OP     = '0;
    bus.i_Funct3 = '0;
    bus.i_Funct7 = '0;
    bus.i_RS1    = '0;
    bus.i_RS2    = '0;
    bus.i_RD     = '0;
    bus.i_IMM    = '0;

    // Reset
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_o_inst", bus.o_Inst, 32'h0);
    counts("rst");
    idle(1);

    // Legal encodings
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5);           // ADDI x1,x0,5
    step(1'b1, 32'h00500093);
    idle(1);
    counts("addi");
    drive(7'b0110111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345000);    // LUI x5
    step(1'b1, 32'h123452B7);
    drive(7'b0010011, 3'b101, 7'b0100000, 5'd3, 5'd0, 5'd3, 32'd4);      // SRAI x3,x3,4
    step(1'b1, 32'h4041D193);
    drive(7'b1100011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC);    // BEQ x1,x2,-4
    step(1'b1, 32'hFE208EE3);
    drive(7'b0100011, 3'b010, 7'h00, 5'd3, 5'd2, 5'd0, 32'hFFFFFFF8);    // SW x2,-8(x3)
    step(1'b1, 32'hFE21AC23);
    drive(7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd8);           // JAL x1,8
    step(1'b1, 32'h008000EF);
    drive(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0);           // ADD x3,x1,x2
    step(1'b1, 32'h002081B3);
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFF800);    // ADDI -2048 edge
    step(1'b1, 32'h80000093);
    idle(3);
    counts("legal");

    // Illegal transfers
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048);        // imm out of range
    step(1'b0, 32'h0);
    drive(7'b1100011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 32'd3);           // odd branch offset
    step(1'b0, 32'h0);
    drive(7'b1111111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0);           // unknown opcode
    step(1'b0, 32'h0);
    idle(2);
    counts("illegal3");
    drive(7'b0010011, 3'b001, 7'h00, 5'd1, 5'd0, 5'd1, 32'd32);          // SLLI shamt 32
    step(1'b0, 32'h0);
    drive(7'b0110011, 3'b001, 7'b0100000, 5'd1, 5'd2, 5'd3, 32'h0);      // bad funct7
    step(1'b0, 32'h0);
    idle(2);
    counts("illegal5");

    // Backpressure: full FIFO holds ready low until a pop has happened
    bus.i_Ready = 1'b0;
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd1);
    step(1'b1, 32'h00100093);
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2);
    step(1'b1, 32'h00200093);
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd3);
    step(1'b1, 32'h00300093);
    step(1'b1, 32'h00300093);
    chk("bp_ready_low", 32'(bus.o_Ready), 32'h0);
    bus.i_Ready = 1'b1;
    for (int i = 0; i < 6 && exp_cnt != 16'd11; i++) step(1'b1, 32'h00300093);
    chk("bp_third_accepted", 32'(exp_cnt), 32'd11);
    idle(1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    chk("bp_drained", 32'(exp_q.size()), 32'h0);
    counts("bp");

    // Reset with two words buffered
    bus.i_Ready = 1'b0;
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd1);
    step(1'b1, 32'h00100093);
    step(1'b1, 32'h00100093);
    bus.i_Valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.o_Valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.o_Valid), 32'h0);
    chk("rst_async_ready", 32'(bus.o_Ready), 32'h1);
    exp_q.delete();
    err_exp  = 1'b0;
    exp_cnt  = '0;
    exp_errc = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.i_Ready = 1'b1;
    counts("post_rst");
    idle(2);
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5);
    step(1'b1, 32'h00500093);
    idle(3);
    counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/encoder_rv32i.md
Name: encoder_rv32i

Overview:
Streaming RV32I instruction encoder. It takes decoded fields (opcode, funct3, funct7, rs1, rs2, rd, immediate) over a valid/ready handshake, checks them for legality, and packs them into a 32-bit instruction word. Legal words are buffered in an output FIFO. It is the inverse of the RV32I field decoder and is used by the on-chip program loader and by self-check benches.

Parameters:
REG_WIDTH, 5, register index width; must be <=5; zero-extended into the 5-bit instruction fields
FIFO_DEPTH, 2, output FIFO entries; power of 2, >=2
COUNT_WIDTH, 16, width of the emitted-word and error counters

Ports:
i_Clock  in  1  single clock, rising edge
i_Reset  in  1  asynchronous, active-low reset
i_Valid  in  1  input fields valid
o_Ready  out  1  encoder can accept fields (FIFO not full)
i_OP  in  7  opcode
i_Funct3  in  3  funct3
i_Funct7  in  7  funct7 (R-type, shift-immediate)
i_RS1  in  REG_WIDTH  source register 1
i_RS2  in  REG_WIDTH  source register 2
i_RD  in  REG_WIDTH  destination register
i_IMM  in  32  immediate, in the same form the decoder produces
o_Valid  out  1  encoded word available
i_Ready  in  1  downstream accepts word
o_Inst  out  32  encoded instruction (FIFO head)
o_Error  out  1  one-cycle pulse: an accepted transfer was illegal
o_Count  out  COUNT_WIDTH  legal words pushed; wraps
o_ErrCount  out  COUNT_WIDTH  illegal transfers; saturates at all-ones

Behaviour:
- Reset (async assert, sync release): FIFO emptied, o_Valid=0, o_Inst=0, o_Error=0, o_Count=0, o_ErrCount=0. o_Ready=1 on the first cycle after release.
- Input transfer: i_Valid & o_Ready on a rising edge.
- o_Ready = !full. It is registered from occupancy and does not depend on field legality.
- Format classification by i_OP:
  - 0110111/0010111 -> U
  - 1101111 -> J
  - 1100111 -> I, and requires funct3=000
  - 1100011 -> B, and requires funct3 not in {010, 011}
  - 0000011 -> I, and requires funct3 in {000, 001, 010, 100, 101}
  - 0100011 -> S, and requires funct3 in {000, 001, 010}
  - 0010011 with funct3 001/101 -> shift-I; all other funct3 -> I
  - 0110011 -> R, and requires funct7 in {0000000, 0100000}; 0100000 only with funct3 000/101
  - any other opcode -> illegal
- Immediate legality:
  - I/S: IMM in [-2048, 2047], i.e. IMM[31:11] all equal.
  - B: IMM[31:12] all equal and IMM[0]=0.
  - J: IMM[31:20] all equal and IMM[0]=0.
  - U: IMM[11:0]=0.
  - shift-I: IMM[31:5]=0; funct7=0000000, or 0100000 only with funct3=101.
- Packing follows the standard RV32I R/I/S/B/U/J layouts. For shift-I, inst[31:25]=i_Funct7 and inst[24:20]=IMM[4:0].
- Latency: a transfer accepted at edge k makes the word visible on o_Inst with o_Valid=1 after edge k (1 cycle) when the FIFO was empty.
- Legal transfer: push to FIFO; o_Count+1.
- Illegal transfer: no push; o_Error=1 for the cycle after edge k; o_ErrCount+1 (saturating).
- Output side: pop on o_Valid & i_Ready. o_Inst is stable while o_Valid=1 and i_Ready=0.
- Simultaneous push and pop: occupancy unchanged; both take effect. With FIFO_DEPTH entries full, o_Ready=0, so no push occurs even if a pop happens the same edge (no combinational ready path).
- FIFO pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
- Reset mid-operation: contents discarded, o_Valid drops immediately (asynchronously), counters cleared.

Decomposition:
- Shared types package:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG)
  - enum inst_fmt_t {FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL}
- Sub-module sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH) holds the buffering.
- Classification, legality and packing are combinational in encoder_rv32i.

Test Plan:
- ADDI: OP=0010011, f3=000, rd=1, rs1=0, IMM=5 -> o_Inst=0x00500093 one cycle later; o_Count=1.
- LUI: OP=0110111, rd=5, IMM=0x12345000 -> 0x123452B7. SRAI: f7=0100000, f3=101, rd=rs1=3, IMM=4 -> 0x4041D193.
- BEQ: OP=1100011, f3=000, rs1=1, rs2=2, IMM=0xFFFFFFFC -> 0xFE208EE3.
- Illegal: ADDI IMM=2048, then BEQ IMM=3, then OP=1111111 -> no o_Valid; three o_Error pulses; o_ErrCount=3; o_Count unchanged.
- Backpressure: i_Ready=0, offer 3 legal ADDIs back-to-back -> 2 accepted, o_Ready=0. Raise i_Ready -> words drain in order, third accepted, no loss or duplication.
- Reset: assert i_Reset with 2 words buffered -> o_Valid=0 asynchronously; after release counters=0 and o_Ready=1.
